// File: rtl/kernel_frame_sequencer.sv
// Configuration sequencer for the 3x3 convolution datapath. It collects coefficient writes and
// mode requests in shadow state, then commits them to the live outputs on each vsync falling edge.
module kernel_frame_sequencer #(
  parameter int unsigned PRECISION   = 16,
  parameter int unsigned COEF_W      = 4,
  parameter int unsigned NUM_MODES   = 15,
  parameter int unsigned AUTO_FRAMES = 120
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   vs,
  input  logic [3:0]                             mode_req,
  input  logic                                   auto_en,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [1:0]                             wr_row,
  input  logic [1:0]                             wr_col,
  input  logic signed [COEF_W-1:0]               wr_data,
  output logic signed [2:0][2:0][PRECISION-1:0]  kernel,
  output logic [3:0]                             active_mode,
  output logic                                   commit_pulse,
  output logic                                   pending,
  output logic                                   bad_wr,
  output logic [7:0]                             frame_count
);

  typedef enum logic [0:0] {StIdle, StCommit} state_e;

  typedef logic [2:0][2:0][PRECISION-1:0] kern_t;

  state_e                       state;
  logic                         vs_d1, vs_d2;
  logic                         frame_edge;
  kern_t                        shadow;
  logic [3:0]                   next_mode;
  logic [3:0]                   next_mode_d;
  logic [3:0]                   mode_step;
  logic                         auto_wrap;
  logic                         addr_bad;
  logic signed [PRECISION-1:0]  coef_ext;

  assign frame_edge = vs_d2 & ~vs_d1;
  assign wr_ready   = ~reset & (state == StIdle) & ~frame_edge;
  assign addr_bad   = (wr_row == 2'd3) | (wr_col == 2'd3);
  assign coef_ext   = PRECISION'(wr_data);
  assign auto_wrap  = ({24'd0, frame_count} == AUTO_FRAMES - 1);

  always_comb begin
    mode_step   = ({28'd0, active_mode} >= NUM_MODES - 1) ? 4'd0 : active_mode + 4'd1;
    next_mode_d = '0;
    if (auto_en) begin
      next_mode_d = auto_wrap ? mode_step : active_mode;
    end else if ({28'd0, mode_req} < NUM_MODES) begin
      next_mode_d = mode_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Sync flops start high so releasing reset cannot fake a falling edge.
      vs_d1        <= 1'b1;
      vs_d2        <= 1'b1;
      state        <= StIdle;
      kernel       <= '0;
      kernel[1][1] <= PRECISION'(1);
      shadow       <= '0;
      shadow[1][1] <= PRECISION'(1);
      active_mode  <= '0;
      next_mode    <= '0;
      commit_pulse <= 1'b0;
      pending      <= 1'b0;
      bad_wr       <= 1'b0;
      frame_count  <= '0;
    end else begin
      vs_d1        <= vs;
      vs_d2        <= vs_d1;
      commit_pulse <= 1'b0;
      if (!auto_en) begin
        frame_count <= '0;
      end
      unique case (state)
        StIdle: begin
          if (frame_edge) begin
            state     <= StCommit;
            next_mode <= next_mode_d;
            if (auto_en) begin
              frame_count <= auto_wrap ? 8'd0 : frame_count + 8'd1;
            end
          end else if (wr_valid) begin
            if (addr_bad) begin
              bad_wr <= 1'b1;
            end else begin
              shadow[wr_row][wr_col] <= coef_ext;
              pending                <= 1'b1;
            end
          end
        end
        StCommit: begin
          kernel       <= shadow;
          active_mode  <= next_mode;
          commit_pulse <= 1'b1;
          pending      <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_frame_sequencer.sv
// Self-checking bench for kernel_frame_sequencer: directed frames plus random write bursts,
// compared against a frame-level model of shadow/live kernel and mode selection.
module tb_kernel_frame_sequencer;

  localparam int NUM_MODES   = 15;
  localparam int AUTO_FRAMES = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   vs;
  logic [3:0]             mode_req;
  logic                   auto_en;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [1:0]             wr_row;
  logic [1:0]             wr_col;
  logic [3:0]             wr_data;
  logic [2:0][2:0][15:0]  kernel;
  logic [3:0]             active_mode;
  logic                   commit_pulse;
  logic                   pending;
  logic                   bad_wr;
  logic [7:0]             frame_count;

  kernel_frame_sequencer #(
    .PRECISION  (16),
    .COEF_W     (4),
    .NUM_MODES  (NUM_MODES),
    .AUTO_FRAMES(AUTO_FRAMES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vs          (vs),
    .mode_req    (mode_req),
    .auto_en     (auto_en),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .kernel      (kernel),
    .active_mode (active_mode),
    .commit_pulse(commit_pulse),
    .pending     (pending),
    .bad_wr      (bad_wr),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model
  int m_shadow [3][3];
  int m_kernel [3][3];
  int m_mode;
  int m_fc;
  bit m_pending;
  bit m_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sext4(input int d);
    return (d >= 8) ? d - 16 : d;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        m_shadow[r][c] = (r == 1 && c == 1) ? 1 : 0;
        m_kernel[r][c] = m_shadow[r][c];
      end
    end
    m_mode    = 0;
    m_fc      = 0;
    m_pending = 0;
    m_bad     = 0;
  endtask

  // Mode choice taken at the frame edge, from the current inputs and committed mode.
  task automatic m_frame_mode();
    if (auto_en) begin
      if (m_fc == AUTO_FRAMES - 1) begin
        m_fc   = 0;
        m_mode = (m_mode + 1) % NUM_MODES;
      end else begin
        m_fc++;
      end
    end else begin
      m_fc   = 0;
      m_mode = (int'(mode_req) >= NUM_MODES) ? 0 : int'(mode_req);
    end
  endtask

  task automatic chk_kernel(input string tag);
    logic [15:0] e;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        e = 16'(m_kernel[r][c]);
        chk($sformatf("%s k%0d%0d", tag, r, c), {16'd0, kernel[r][c]}, {16'd0, e});
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk_kernel(tag);
    chk({tag, " mode"}, {28'd0, active_mode}, 32'(m_mode));
    chk({tag, " pend"}, {31'd0, pending}, {31'd0, m_pending});
    chk({tag, " bad"}, {31'd0, bad_wr}, {31'd0, m_bad});
    chk({tag, " fc"}, {24'd0, frame_count}, 32'(m_fc));
  endtask

  // Single-cycle write issued at a negedge while idle; accepted at the next posedge.
  task automatic do_write(input string tag, input int r, input int c, input int d);
    wr_valid = 1'b1;
    wr_row   = 2'(r);
    wr_col   = 2'(c);
    wr_data  = 4'(d);
    chk({tag, " rdy"}, {31'd0, wr_ready}, 32'd1);
    if (r == 3 || c == 3) begin
      m_bad = 1;
    end else begin
      m_shadow[r][c] = sext4(d);
      m_pending      = 1;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // vs falls in the current cycle; new kernel is visible in the 4th cycle counting this one.
  task automatic do_frame(input string tag);
    chk({tag, " pend pre"}, {31'd0, pending}, {31'd0, m_pending});
    vs = 1'b0;
    @(negedge clk);
    chk({tag, " edge rdy"}, {31'd0, wr_ready}, 32'd0);
    chk({tag, " edge cp"}, {31'd0, commit_pulse}, 32'd0);
    m_frame_mode();
    @(negedge clk);
    chk({tag, " commit rdy"}, {31'd0, wr_ready}, 32'd0);
    chk({tag, " commit cp"}, {31'd0, commit_pulse}, 32'd0);
    chk_kernel({tag, " old"});
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        m_kernel[r][c] = m_shadow[r][c];
      end
    end
    m_pending = 0;
    @(negedge clk);
    chk({tag, " cp"}, {31'd0, commit_pulse}, 32'd1);
    chk_state(tag);
    @(negedge clk);
    chk({tag, " cp off"}, {31'd0, commit_pulse}, 32'd0);
    vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int n;

    reset    = 1'b1;
    vs       = 1'b1;
    mode_req = '0;
    auto_en  = 1'b0;
    wr_valid = 1'b0;
    wr_row   = '0;
    wr_col   = '0;
    wr_data  = '0;
    m_reset();

    // 1: reset and idle frame
    repeat (3) @(negedge clk);
    chk("t1 rdy in reset", {31'd0, wr_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t1 rdy", {31'd0, wr_ready}, 32'd1);
    chk_state("t1");
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (commit_pulse) pulses++;
    end
    chk("t1 no pulses", 32'(pulses), 32'd0);

    // 2: two writes then a frame
    do_write("t2 w0", 1, 1, 13);
    do_write("t2 w1", 0, 2, 7);
    chk("t2 pend", {31'd0, pending}, 32'd1);
    do_frame("t2");
    chk("t2 k11 raw", {16'd0, kernel[1][1]}, 32'h0000_FFFD);

    // 3: wr_valid held across the edge with a changing address
    vs       = 1'b0;
    wr_valid = 1'b1;
    wr_row   = 2'd0; wr_col = 2'd0; wr_data = 4'h5;
    chk("t3 pre rdy", {31'd0, wr_ready}, 32'd1);
    m_shadow[0][0] = 5;
    m_pending      = 1;
    @(negedge clk);
    wr_row = 2'd1; wr_col = 2'd0; wr_data = 4'h9;
    chk("t3 edge rdy", {31'd0, wr_ready}, 32'd0);
    m_frame_mode();
    @(negedge clk);
    wr_row = 2'd2; wr_col = 2'd0; wr_data = 4'h3;
    chk("t3 commit rdy", {31'd0, wr_ready}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        m_kernel[r][c] = m_shadow[r][c];
      end
    end
    m_pending = 0;
    @(negedge clk);
    wr_row = 2'd2; wr_col = 2'd2; wr_data = 4'hA;
    chk("t3 post rdy", {31'd0, wr_ready}, 32'd1);
    chk("t3 cp", {31'd0, commit_pulse}, 32'd1);
    chk_kernel("t3 live");
    m_shadow[2][2] = sext4(10);
    m_pending      = 1;
    @(negedge clk);
    wr_valid = 1'b0;
    vs       = 1'b1;
    chk("t3 pend after", {31'd0, pending}, 32'd1);
    chk_kernel("t3 shadow only");
    repeat (3) @(negedge clk);
    do_frame("t3 next");

    // 4: mode_req out of range maps to 0
    mode_req = 4'd12;
    do_frame("t4 f1");
    mode_req = 4'd15;
    do_frame("t4 f2");

    // 5: auto-cycle from mode 14, wrap on the 3rd edge
    mode_req = 4'd14;
    do_frame("t5 set14");
    auto_en  = 1'b1;
    mode_req = 4'd3;
    do_frame("t5 a1");
    do_frame("t5 a2");
    do_frame("t5 a3");
    do_frame("t5 a4");
    auto_en = 1'b0;
    @(negedge clk);
    m_fc = 0;
    chk("t5 fc clear", {24'd0, frame_count}, 32'd0);
    mode_req = 4'd6;
    do_frame("t5 manual");

    // Random write bursts and mode requests
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 5);
      for (int w = 0; w < n; w++) begin
        do_write($sformatf("rnd f%0d w%0d", f, w), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      mode_req = 4'($urandom_range(0, 15));
      do_frame($sformatf("rnd f%0d", f));
    end

    // 6: bad address, then reset in the edge cycle
    do_frame("t6 clean");
    do_write("t6 bad", 3, 0, 5);
    chk("t6 bad", {31'd0, bad_wr}, 32'd1);
    chk("t6 pend", {31'd0, pending}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6 bad sticky", {31'd0, bad_wr}, 32'd1);
    do_frame("t6 bad frame");
    do_write("t6 w", 0, 0, 6);
    vs = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    vs       = 1'b1;
    wr_valid = 1'b1;
    wr_row   = 2'd1; wr_col = 2'd1; wr_data = 4'h2;
    chk("t6 rdy in reset", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    m_reset();
    chk_state("t6 after reset");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (commit_pulse) pulses++;
    end
    chk("t6 no spurious", 32'(pulses), 32'd0);
    mode_req = 4'd0;
    do_frame("t6 post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
